// File: rtl/spi_controller.sv
// SPI mode-0 controller: one W-bit MSB-first transfer per start request,
// p_clk divided from sys_clk by CLK_DIV, one-hot active-low selects.
module spi_controller #(
  parameter int SPI_DATA_WIDTH = 8,
  parameter int P_ADDR_WIDTH   = 2,
  parameter int PERI_CNT       = 4,
  parameter int CLK_DIV        = 4
) (
  input  logic                      sys_clk,
  input  logic                      sync_rst,
  input  logic                      sys_clk_en,
  input  logic                      start_txn,
  input  logic [SPI_DATA_WIDTH-1:0] tx_data,
  input  logic [P_ADDR_WIDTH-1:0]   p_addr,
  input  logic                      cipo,
  output logic                      copi,
  output logic                      p_clk,
  output logic [PERI_CNT-1:0]       p_sel_n,
  output logic                      end_txn,
  output logic [15:0]               clk_counter,
  output logic [SPI_DATA_WIDTH-1:0] rx_data,
  output logic                      busy
);

  localparam int W = SPI_DATA_WIDTH;
  localparam logic [15:0] CDIV_M1 = 16'(CLK_DIV - 1);
  localparam logic [6:0] LAST_TOG = 7'(2 * W - 1);
  localparam logic [P_ADDR_WIDTH:0] PCNT = (P_ADDR_WIDTH + 1)'(PERI_CNT);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DONE
  } state_t;

  state_t         state;
  logic [W-1:0]   tx_shift;
  logic [W-1:0]   rx_shift;
  logic [6:0]     tog_cnt;
  logic [W-1:0]   tx_nxt;
  logic [W-1:0]   rx_nxt;
  logic           addr_ok;

  assign tx_nxt  = tx_shift << 1;
  assign rx_nxt  = (rx_shift << 1) | W'(cipo);
  assign addr_ok = {1'b0, p_addr} < PCNT;
  assign busy    = (state != IDLE);

  always_ff @(posedge sys_clk) begin
    if (sync_rst) begin
      state       <= IDLE;
      p_clk       <= 1'b0;
      p_sel_n     <= '1;
      copi        <= 1'b0;
      end_txn     <= 1'b0;
      clk_counter <= '0;
      rx_data     <= '0;
      tx_shift    <= '0;
      rx_shift    <= '0;
      tog_cnt     <= '0;
    end else if (sys_clk_en) begin
      end_txn <= 1'b0;
      unique case (state)
        IDLE: begin
          copi        <= 1'b0;
          clk_counter <= '0;
          p_clk       <= 1'b0;
          if (start_txn && addr_ok) begin
            tx_shift <= tx_data;
            rx_shift <= '0;
            tog_cnt  <= '0;
            p_sel_n  <= ~(PERI_CNT'(1) << p_addr);
            copi     <= tx_data[W-1];
            state    <= XFER;
          end
        end
        XFER: begin
          if (clk_counter == CDIV_M1) begin
            clk_counter <= '0;
            p_clk       <= ~p_clk;
            tog_cnt     <= tog_cnt + 7'd1;
            // p_clk low now means this toggle is a rising edge
            if (!p_clk) begin
              rx_shift <= rx_nxt;
            end else if (tog_cnt == LAST_TOG) begin
              state   <= DONE;
              p_sel_n <= '1;
              rx_data <= rx_shift;
              end_txn <= 1'b1;
              copi    <= 1'b0;
            end else begin
              tx_shift <= tx_nxt;
              copi     <= tx_nxt[W-1];
            end
          end else begin
            clk_counter <= clk_counter + 16'd1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_controller.sv
// Self-checking bench for spi_controller: vector table of transfers,
// rx scoreboard, plus reset corner sequences.
module tb_spi_controller;

  logic       sys_clk = 1'b0;
  logic       sync_rst;
  logic       sys_clk_en;
  logic       start_txn;
  logic [7:0] tx_data;
  logic [1:0] p_addr;
  logic       cipo;
  logic       copi;
  logic       p_clk;
  logic [3:0] p_sel_n;
  logic       end_txn;
  logic [15:0] clk_counter;
  logic [7:0] rx_data;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cmode  = 0;

  logic [7:0] sb_q[$];

  typedef struct {
    logic [7:0] tx;
    logic [1:0] addr;
    int         mode;
    int         ign_at;
    int         off_at;
    logic [3:0] exp_sel;
    logic [7:0] exp_rx;
    int         exp_lat;
  } vec_t;

  vec_t vecs[5];

  spi_controller dut (
    .sys_clk    (sys_clk),
    .sync_rst   (sync_rst),
    .sys_clk_en (sys_clk_en),
    .start_txn  (start_txn),
    .tx_data    (tx_data),
    .p_addr     (p_addr),
    .cipo       (cipo),
    .copi       (copi),
    .p_clk      (p_clk),
    .p_sel_n    (p_sel_n),
    .end_txn    (end_txn),
    .clk_counter(clk_counter),
    .rx_data    (rx_data),
    .busy       (busy)
  );

  always #5 sys_clk = ~sys_clk;

  always_comb begin
    cipo = 1'b0;
    if (cmode == 0) cipo = copi;
    else if (cmode == 1) cipo = 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic run_txn(input vec_t v);
    int cyc;
    int end_cyc;
    int pulses;
    int last_rise;
    int per_bad;
    int sel_bad;
    int frz_bad;
    int extra_end;
    logic prev_pclk;
    logic [7:0] bits;
    logic [15:0] snap_cnt;
    logic snap_pclk;
    end_cyc = 0; pulses = 0; last_rise = 0; per_bad = 0;
    sel_bad = 0; frz_bad = 0; extra_end = 0;
    prev_pclk = 1'b0; bits = '0; snap_cnt = '0; snap_pclk = 1'b0;
    cmode = v.mode;
    tick();
    start_txn = 1'b1;
    tx_data   = v.tx;
    p_addr    = v.addr;
    sb_q.push_back(v.exp_rx);
    for (cyc = 1; cyc <= 200; cyc++) begin
      tick();
      if (cyc == 1) begin
        start_txn = 1'b0;
        chk("busy_start", busy, 1);
        chk("sel_start", p_sel_n, v.exp_sel);
        chk("copi_msb", copi, v.tx[7]);
        chk("cnt_start", clk_counter, 0);
      end
      if (v.ign_at != 0 && cyc == v.ign_at) begin
        start_txn = 1'b1;
        p_addr    = 2'd1;
        tx_data   = 8'h00;
      end
      if (v.ign_at != 0 && cyc == v.ign_at + 1) start_txn = 1'b0;
      if (v.off_at != 0) begin
        if (cyc == v.off_at) begin
          sys_clk_en = 1'b0;
          snap_cnt   = clk_counter;
          snap_pclk  = p_clk;
        end else if (cyc > v.off_at && cyc <= v.off_at + 10) begin
          if (clk_counter !== snap_cnt || p_clk !== snap_pclk) frz_bad++;
          if (cyc == v.off_at + 10) sys_clk_en = 1'b1;
        end
      end
      if (end_cyc == 0 && p_sel_n !== v.exp_sel && !end_txn) sel_bad++;
      if (p_clk && !prev_pclk) begin
        pulses++;
        bits = {bits[6:0], copi};
        if (last_rise != 0 && cyc - last_rise != 8) per_bad++;
        last_rise = cyc;
      end
      prev_pclk = p_clk;
      if (end_cyc != 0 && end_txn) extra_end++;
      if (end_cyc == 0 && end_txn) begin
        end_cyc = cyc;
        chk("end_lat", cyc, v.exp_lat);
        chk("sel_done", p_sel_n, 4'hF);
        chk("pclk_idle", p_clk, 0);
        if (sb_q.size() == 0) chk("sb_empty", 1, 0);
        else chk("rx_data", rx_data, sb_q.pop_front());
      end
      if (end_cyc != 0 && cyc == end_cyc + 2) begin
        chk("busy_after", busy, 0);
        chk("copi_idle", copi, 0);
        chk("cnt_idle", clk_counter, 0);
        chk("rx_hold", rx_data, v.exp_rx);
      end
      if (end_cyc != 0 && cyc == end_cyc + 3) break;
    end
    if (end_cyc == 0) chk("end_timeout", 0, 1);
    chk("pulses", pulses, 8);
    chk("copi_bits", bits, v.tx);
    chk("sel_during", sel_bad, 0);
    chk("single_end", extra_end, 0);
    if (v.off_at == 0) chk("pclk_period", per_bad, 0);
    else chk("freeze", frz_bad, 0);
  endtask

  initial begin
    int ends;
    vecs[0] = '{8'hA5, 2'd2, 0, 0, 0, 4'b1011, 8'hA5, 65};
    vecs[1] = '{8'h3C, 2'd0, 1, 0, 0, 4'b1110, 8'hFF, 65};
    vecs[2] = '{8'h5A, 2'd3, 2, 0, 0, 4'b0111, 8'h00, 65};
    vecs[3] = '{8'h96, 2'd2, 0, 20, 0, 4'b1011, 8'h96, 65};
    vecs[4] = '{8'h81, 2'd1, 0, 0, 30, 4'b1101, 8'h81, 75};

    sync_rst   = 1'b1;
    sys_clk_en = 1'b0;
    start_txn  = 1'b0;
    tx_data    = '0;
    p_addr     = '0;
    tick();
    chk("rst_pclk", p_clk, 0);
    chk("rst_sel", p_sel_n, 4'hF);
    chk("rst_copi", copi, 0);
    chk("rst_end", end_txn, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", clk_counter, 0);
    chk("rst_rx", rx_data, 0);
    sync_rst   = 1'b0;
    sys_clk_en = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) run_txn(vecs[i]);

    // abort mid-transfer with reset
    cmode = 0;
    start_txn = 1'b1;
    tx_data   = 8'hA5;
    p_addr    = 2'd2;
    ends = 0;
    for (int c = 1; c <= 29; c++) begin
      tick();
      if (c == 1) start_txn = 1'b0;
      if (end_txn) ends++;
    end
    chk("pre_rst_busy", busy, 1);
    sync_rst = 1'b1;
    tick();
    sync_rst = 1'b0;
    chk("abort_sel", p_sel_n, 4'hF);
    chk("abort_pclk", p_clk, 0);
    chk("abort_end", end_txn, 0);
    chk("abort_rx", rx_data, 0);
    chk("abort_busy", busy, 0);
    for (int c = 0; c < 80; c++) begin
      tick();
      if (end_txn || busy) ends++;
    end
    chk("abort_quiet", ends, 0);
    chk("sb_drained", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_controller.md
SPI_CONTROLLER -- requirements
Module: spi_controller

Interface
REQ-001 Parameter SPI_DATA_WIDTH, default 8, SHALL set the bits per transaction (W), legal range 1..32.
REQ-002 Parameter P_ADDR_WIDTH, default 2, SHALL set the peripheral address width.
REQ-003 Parameter PERI_CNT, default 4, SHALL set the peripheral-select count, with PERI_CNT <= 2^P_ADDR_WIDTH.
REQ-004 Parameter CLK_DIV, default 4, SHALL set the enabled sys_clk cycles per p_clk half-period, legal range 1..65535.
REQ-005 sys_clk  in  1  SHALL be the single clock; all logic is on its rising edge.
REQ-006 sync_rst  in  1  SHALL be the reset, which is synchronous and active-high.
REQ-007 sys_clk_en  in  1  SHALL be the clock enable; when it is 0, all registers hold.
REQ-008 start_txn  in  1  SHALL be the transaction request, sampled in IDLE only.
REQ-009 tx_data  in  W  SHALL be the transmit word, latched when start is accepted.
REQ-010 p_addr  in  P_ADDR_WIDTH  SHALL be the target peripheral index, latched when start is accepted.
REQ-011 cipo  in  1  SHALL be the serial data input from the peripheral.
REQ-012 copi  out  1  SHALL be the serial data output to the peripheral, MSB first.
REQ-013 p_clk  out  1  SHALL be the SPI clock in mode 0 (CPOL=0, CPHA=0).
REQ-014 p_sel_n  out  PERI_CNT  SHALL be the one-hot active-low chip selects.
REQ-015 end_txn  out  1  SHALL be a one-cycle completion pulse.
REQ-016 clk_counter  out  16  SHALL expose the current half-period divider count.
REQ-017 rx_data  out  W  SHALL hold the last received word.
REQ-018 busy  out  1  SHALL be 1 whenever the state is not IDLE.

Function
REQ-019 The state machine SHALL have states IDLE, XFER and DONE; every transition occurs only on enabled cycles (sys_clk_en=1).
REQ-020 In IDLE, start_txn=1 with p_addr<PERI_CNT SHALL cause the following on the next cycle: latch tx_data and p_addr, drive p_sel_n[p_addr]=0 (others 1), set copi=tx_data[W-1], set clk_counter=0, and enter XFER.
REQ-021 In IDLE, start_txn with p_addr>=PERI_CNT SHALL be ignored: no state change and no end_txn.
REQ-022 In XFER, clk_counter SHALL increment each enabled cycle; at CLK_DIV-1 it SHALL wrap to 0 and p_clk SHALL toggle.
REQ-023 On each p_clk rising toggle, cipo SHALL be shifted into the LSB of the receive shift register.
REQ-024 On each p_clk falling toggle, except the last, copi SHALL advance to the next lower tx bit.
REQ-025 A transaction SHALL consist of exactly W p_clk pulses (2W toggles), and p_clk SHALL idle at 0.
REQ-026 On the 2W-th toggle the controller SHALL enter DONE, drive p_sel_n all ones, load rx_data from the shift register, and assert end_txn for exactly one cycle.
REQ-027 DONE SHALL return to IDLE on the next enabled cycle; a new start is accepted only in IDLE.
REQ-028 Timing: start sampled in enabled cycle N SHALL produce end_txn in cycle N+1+2*W*CLK_DIV when enable is continuous (N+65 with defaults).
REQ-029 Every cycle with sys_clk_en=0 SHALL extend the transaction by exactly one cycle with no glitch on any output.
REQ-030 start_txn during XFER or DONE SHALL be ignored, and tx_data/p_addr changes during XFER SHALL have no effect.
REQ-031 In IDLE: copi=0, clk_counter=0, and rx_data SHALL hold its value.

Reset
REQ-032 sync_rst=1 on a sys_clk edge SHALL override sys_clk_en and yield p_clk=0, p_sel_n all ones, copi=0, end_txn=0, busy=0, clk_counter=0, rx_data=0, state IDLE.
REQ-033 Reset during XFER SHALL abort the transaction immediately with no end_txn pulse and no rx_data update.

Verification
REQ-034 Reset held for 1 cycle -> all outputs at the REQ-032 values, p_sel_n=4'b1111.
REQ-035 tx_data=8'hA5, p_addr=2, cipo looped from copi -> p_sel_n=4'b1011, copi bits 1,0,1,0,0,1,0,1, 8 p_clk pulses of 8 cycles each, end_txn at N+65, rx_data=8'hA5.
REQ-036 tx_data=8'h3C, p_addr=0, cipo=1 -> p_sel_n=4'b1110 during transfer, rx_data=8'hFF, busy=0 two cycles after end_txn.
REQ-037 start_txn with p_addr=1 asserted in cycle N+20 of an active transaction -> ignored, p_sel_n unchanged, a single end_txn.
REQ-038 sys_clk_en=0 for 10 cycles mid-transfer -> p_clk/clk_counter frozen, end_txn at N+75.
REQ-039 sync_rst pulse at cycle N+30 -> next cycle p_sel_n=4'b1111, p_clk=0, no end_txn, rx_data=0.
